// File: rtl/sort_4_if.sv
// Bundle of the sort_4 input set and sorted result.
// The master drives a set to be sorted; the slave (the sorter) returns the ordered set.
interface sort_4_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rc;
    logic [WIDTH-1:0] rd;

    modport master (
        output in_valid, a, b, c, d,
        input  out_valid, ra, rb, rc, rd
    );

    modport slave (
        input  in_valid, a, b, c, d,
        output out_valid, ra, rb, rc, rd
    );
endinterface

// File: rtl/sort_4.sv
// Pipelined four-input unsigned sorting network with 3-cycle latency.
// The network uses five compare-exchange units; each stage's data loads only when that stage carries a valid set.
module sort_4 #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    sort_4_if.slave  bus
);
    // Input capture register, followed by the three CE stages.
    // The capture register sets the result at edge N+3.
    logic             r_v0;
    logic             r_v1;
    logic             r_v2;
    logic             r_v3;
    logic [WIDTH-1:0] r_x0, r_x1, r_x2, r_x3;
    logic [WIDTH-1:0] r_s1_0, r_s1_1, r_s1_2, r_s1_3;
    logic [WIDTH-1:0] r_s2_0, r_s2_1, r_s2_2, r_s2_3;
    logic [WIDTH-1:0] r_ra, r_rb, r_rc, r_rd;

    logic [WIDTH-1:0] w_s1_0, w_s1_1, w_s1_2, w_s1_3;
    logic [WIDTH-1:0] w_s2_0, w_s2_1, w_s2_2, w_s2_3;
    logic [WIDTH-1:0] w_s3_1, w_s3_2;

    always_comb begin
        w_s1_0 = r_x0;
        w_s1_1 = r_x1;
        w_s1_2 = r_x2;
        w_s1_3 = r_x3;
        if (r_x1 < r_x0) begin
            w_s1_0 = r_x1;
            w_s1_1 = r_x0;
        end
        if (r_x3 < r_x2) begin
            w_s1_2 = r_x3;
            w_s1_3 = r_x2;
        end
    end

    always_comb begin
        w_s2_0 = r_s1_0;
        w_s2_1 = r_s1_1;
        w_s2_2 = r_s1_2;
        w_s2_3 = r_s1_3;
        if (r_s1_2 < r_s1_0) begin
            w_s2_0 = r_s1_2;
            w_s2_2 = r_s1_0;
        end
        if (r_s1_3 < r_s1_1) begin
            w_s2_1 = r_s1_3;
            w_s2_3 = r_s1_1;
        end
    end

    always_comb begin
        w_s3_1 = r_s2_1;
        w_s3_2 = r_s2_2;
        if (r_s2_2 < r_s2_1) begin
            w_s3_1 = r_s2_2;
            w_s3_2 = r_s2_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0   <= 1'b0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_x0   <= '0;
            r_x1   <= '0;
            r_x2   <= '0;
            r_x3   <= '0;
            r_s1_0 <= '0;
            r_s1_1 <= '0;
            r_s1_2 <= '0;
            r_s1_3 <= '0;
            r_s2_0 <= '0;
            r_s2_1 <= '0;
            r_s2_2 <= '0;
            r_s2_3 <= '0;
            r_ra   <= '0;
            r_rb   <= '0;
            r_rc   <= '0;
            r_rd   <= '0;
        end else begin
            r_v0 <= bus.in_valid;
            r_v1 <= r_v0;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (bus.in_valid) begin
                r_x0 <= bus.a;
                r_x1 <= bus.b;
                r_x2 <= bus.c;
                r_x3 <= bus.d;
            end
            if (r_v0) begin
                r_s1_0 <= w_s1_0;
                r_s1_1 <= w_s1_1;
                r_s1_2 <= w_s1_2;
                r_s1_3 <= w_s1_3;
            end
            if (r_v1) begin
                r_s2_0 <= w_s2_0;
                r_s2_1 <= w_s2_1;
                r_s2_2 <= w_s2_2;
                r_s2_3 <= w_s2_3;
            end
            if (r_v2) begin
                r_ra <= r_s2_0;
                r_rb <= w_s3_1;
                r_rc <= w_s3_2;
                r_rd <= r_s2_3;
            end
        end
    end

    assign bus.out_valid = r_v3;
    assign bus.ra        = r_ra;
    assign bus.rb        = r_rb;
    assign bus.rc        = r_rc;
    assign bus.rd        = r_rd;
endmodule

// File: tb/tb_sort_4.sv
// Scoreboard bench for sort_4: expected sorted sets are queued at drive time and popped on out_valid.
module tb_sort_4;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    sort_4_if #(.WIDTH(W)) bus ();

    sort_4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [4*W-1:0] sb[$];
    logic [4*W-1:0] last = '0;
    logic [4*W-1:0] got;
    logic [3:0]     vp = '0;

    function automatic logic [4*W-1:0] ref_sort(input logic [W-1:0] p, q, r, s);
        logic [W-1:0] v[4];
        logic [W-1:0] t;
        v[0] = p; v[1] = q; v[2] = r; v[3] = s;
        for (int i = 1; i < 4; i++) begin
            for (int j = i; j > 0; j--) begin
                if (v[j] < v[j-1]) begin
                    t = v[j]; v[j] = v[j-1]; v[j-1] = t;
                end
            end
        end
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Drives one cycle of stimulus, queues the expected result, and steps past the edge.
    task automatic tick(input logic v, input logic [W-1:0] p, q, r, s);
        bus.in_valid = v;
        bus.a = p; bus.b = q; bus.c = r; bus.d = s;
        if (v && rst_n) sb.push_back(ref_sort(p, q, r, s));
        @(posedge clk);
        #1;
        vp = {vp[2:0], v & rst_n};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            if (bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid);
            end
            checks++;
            got = {bus.ra, bus.rb, bus.rc, bus.rd};
            if (got !== '0) begin
                errors++; $display("FAIL reset_data: got %h want 0", got);
            end
            checks++;
        end
        tick(1'b0, '0, '0, '0, '0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            got = {bus.ra, bus.rb, bus.rc, bus.rd};
            if (bus.out_valid !== 1'b0 || got !== '0) begin
                errors++; $display("FAIL reset_idle: got v=%b %h want v=0 0", bus.out_valid, got);
            end
            checks++;
        end
    endtask

    task automatic test_single();
        tick(1'b1, 4'd9, 4'd3, 4'd14, 4'd0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            if (bus.out_valid !== vp[3]) begin
                errors++; $display("FAIL single_valid cyc%0d: got %b want %b", i, bus.out_valid, vp[3]);
            end
            checks++;
            if (vp[3]) begin
                if (sb.size() == 0) begin errors++; $display("FAIL single_sb: got empty want entry"); end
                else last = sb.pop_front();
                checks++;
            end
            got = {bus.ra, bus.rb, bus.rc, bus.rd};
            if (got !== last) begin
                errors++; $display("FAIL single_data cyc%0d: got %h want %h", i, got, last);
            end
            checks++;
        end
        if (last !== 16'h039E) begin
            errors++; $display("FAIL single_model: got %h want 039e", last);
        end
        checks++;
    endtask

    task automatic test_duplicates();
        logic [4*W-1:0] sets[3];
        sets[0] = 16'h7777; sets[1] = 16'hF0F0; sets[2] = 16'h2212;
        for (int i = 0; i < 3 + 4; i++) begin
            if (i < 3) tick(1'b1, sets[i][15:12], sets[i][11:8], sets[i][7:4], sets[i][3:0]);
            else       tick(1'b0, '0, '0, '0, '0);
            if (bus.out_valid !== vp[3]) begin
                errors++; $display("FAIL dup_valid cyc%0d: got %b want %b", i, bus.out_valid, vp[3]);
            end
            checks++;
            if (vp[3]) begin
                if (sb.size() == 0) begin errors++; $display("FAIL dup_sb: got empty want entry"); end
                else last = sb.pop_front();
                checks++;
            end
            got = {bus.ra, bus.rb, bus.rc, bus.rd};
            if (got !== last) begin
                errors++; $display("FAIL dup_data cyc%0d: got %h want %h", i, got, last);
            end
            checks++;
        end
        if (last !== 16'h1222) begin
            errors++; $display("FAIL dup_last: got %h want 1222", last);
        end
        checks++;
    endtask

    task automatic test_streaming();
        int nvalid = 0;
        for (int i = 0; i < 50 + 4; i++) begin
            if (i < 50) tick(1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            else        tick(1'b0, '0, '0, '0, '0);
            if (bus.out_valid !== vp[3]) begin
                errors++; $display("FAIL stream_valid cyc%0d: got %b want %b", i, bus.out_valid, vp[3]);
            end
            checks++;
            if (bus.out_valid === 1'b1) nvalid++;
            if (vp[3]) begin
                if (sb.size() == 0) begin errors++; $display("FAIL stream_sb: got empty want entry"); end
                else last = sb.pop_front();
                checks++;
            end
            got = {bus.ra, bus.rb, bus.rc, bus.rd};
            if (got !== last) begin
                errors++; $display("FAIL stream_data cyc%0d: got %h want %h", i, got, last);
            end
            checks++;
        end
        if (nvalid != 50) begin
            errors++; $display("FAIL stream_count: got %0d want 50", nvalid);
        end
        checks++;
    endtask

    task automatic test_permutations();
        logic [W-1:0] vals[4];
        int n = 0;
        vals[0] = 4'd1; vals[1] = 4'd5; vals[2] = 4'd10; vals[3] = 4'd12;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++)
                    for (int l = 0; l < 4; l++)
                        if (i != j && i != k && i != l && j != k && j != l && k != l) begin
                            tick(1'b1, vals[i], vals[j], vals[k], vals[l]);
                            n++;
                            if (vp[3]) begin
                                got = {bus.ra, bus.rb, bus.rc, bus.rd};
                                void'(sb.pop_front());
                                if (bus.out_valid !== 1'b1 || got !== 16'h15AC) begin
                                    errors++; $display("FAIL perm_data #%0d: got v=%b %h want v=1 15ac", n, bus.out_valid, got);
                                end
                                checks++;
                            end
                        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, '0, '0, '0);
            if (vp[3]) begin
                got = {bus.ra, bus.rb, bus.rc, bus.rd};
                void'(sb.pop_front());
                if (bus.out_valid !== 1'b1 || got !== 16'h15AC) begin
                    errors++; $display("FAIL perm_tail %0d: got v=%b %h want v=1 15ac", i, bus.out_valid, got);
                end
                checks++;
            end
        end
        last = 16'h15AC;
        if (n != 24 || sb.size() != 0) begin
            errors++; $display("FAIL perm_count: got n=%0d sb=%0d want 24 0", n, sb.size());
        end
        checks++;
    endtask

    task automatic test_reset_midstream();
        tick(1'b1, 4'd8, 4'd2, 4'd6, 4'd4);
        tick(1'b1, 4'd3, 4'd3, 4'd1, 4'd15);
        #2 rst_n = 1'b0;
        #1;
        got = {bus.ra, bus.rb, bus.rc, bus.rd};
        if (bus.out_valid !== 1'b0 || got !== '0) begin
            errors++; $display("FAIL mid_async: got v=%b %h want v=0 0", bus.out_valid, got);
        end
        checks++;
        sb.delete();
        vp = '0;
        last = '0;
        tick(1'b1, 4'd5, 4'd6, 4'd7, 4'd8);
        tick(1'b0, '0, '0, '0, '0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) tick(1'b1, 4'd11, 4'd4, 4'd13, 4'd2);
            else        tick(1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            if (bus.out_valid !== vp[3]) begin
                errors++; $display("FAIL mid_valid cyc%0d: got %b want %b", i, bus.out_valid, vp[3]);
            end
            checks++;
            if (vp[3]) begin
                if (sb.size() == 0) begin errors++; $display("FAIL mid_sb: got empty want entry"); end
                else last = sb.pop_front();
                checks++;
            end
            got = {bus.ra, bus.rb, bus.rc, bus.rd};
            if (got !== last) begin
                errors++; $display("FAIL mid_data cyc%0d: got %h want %h", i, got, last);
            end
            checks++;
        end
        if (last !== 16'h24BD) begin
            errors++; $display("FAIL mid_last: got %h want 24bd", last);
        end
        checks++;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
        test_reset();
        test_single();
        test_duplicates();
        test_streaming();
        test_permutations();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
